// File: rtl/core_pkg.sv
// Shared core types: memory direction/size (also used by the decoder) and MEM-stage states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
// Contents: mem_dir_e, mem_size_e, mem_state_e, is_misaligned().
package core_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_dir_e;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_BU = 3'd1,
    MEM_H  = 3'd2,
    MEM_HU = 3'd3,
    MEM_W  = 3'd4
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
    case (size)
      MEM_H, MEM_HU: return a[0];
      MEM_W:         return (a != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_lane.sv
// Byte-lane steering for the MEM stage: store replication/strobes, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: size, addr_lo (addr[1:0]), wdata, rdata in; wstrb, wdata_rep, rdata_ext, misaligned out.
// Build option CORE_MEM_MISALIGN_TRAP_EN: when defined, misaligned reports misaligned
// sizes/offsets; otherwise it is 0 and the offending low address bits are simply dropped.
module core_mem_lane
  import core_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [1:0]  a;
  logic [31:0] sh;

  always_comb begin
    // Effective offset: halfwords drop bit 0, words drop both bits. A trapped access never
    // reaches the bus, so the same alignment is harmless in the trap build.
    a = addr_lo;
    case (size)
      MEM_H, MEM_HU: a = {addr_lo[1], 1'b0};
      MEM_W:         a = 2'b00;
      default:       a = addr_lo;
    endcase

    sh        = rdata >> {a, 3'b000};
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = sh;

    case (size)
      MEM_B, MEM_BU: begin
        wstrb     = 4'b0001 << a;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (size == MEM_B) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end
      MEM_H, MEM_HU: begin
        wstrb     = 4'b0011 << a;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (size == MEM_H) ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = sh;
      end
    endcase
  end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(size, addr_lo);
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/core_stage_mem.sv
// MEM stage: captures EXEC's memory request, runs one data-bus transaction, returns extended load data.
// Latency: valid at N -> bus_req_valid at N+1 -> mem_stage_ready at N+3 with a zero-wait bus.
// Backpressure: waits indefinitely in REQ (holding the request stable) and in RESP.
// Ports: clk, rstn; controller mem_stage_valid/mem_stage_ready; EXEC mem_addr/mem_wdata/mem_dir/mem_size;
// data bus bus_req_* / bus_rsp_*; mem_rdata to write-back; mem_misaligned valid with mem_stage_ready.
// Build option CORE_MEM_MISALIGN_TRAP_EN: misaligned requests skip the bus and flag mem_misaligned.
module core_stage_mem
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_stage_valid,
  output logic        mem_stage_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  mem_dir_e    mem_dir,
  input  mem_size_e   mem_size,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_we,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_misaligned
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  mem_dir_e    dir_q;
  mem_size_e   size_q;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_mis;

  // Lane logic works on the captured request so EXEC may move on after capture.
  core_mem_lane u_lane (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (bus_rsp_rdata),
    .wstrb     (lane_wstrb),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata),
    .misaligned(lane_mis)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      dir_q     <= MEM_READ;
      size_q    <= MEM_B;
      mem_rdata <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && mem_stage_valid) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        dir_q   <= mem_dir;
        size_q  <= mem_size;
      end
      if (state_q == RESP && bus_rsp_valid && dir_q == MEM_READ) begin
        mem_rdata <= lane_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_stage_valid) begin
`ifdef CORE_MEM_MISALIGN_TRAP_EN
          // Decided from the live inputs: the capture registers load on this same edge.
          state_d = is_misaligned(mem_size, mem_addr[1:0]) ? DONE : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ:     if (bus_req_ready) state_d = RESP;
      RESP:    if (bus_rsp_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus_req_valid   = (state_q == REQ);
  assign mem_stage_ready = (state_q == DONE);
  assign bus_req_addr    = {addr_q[31:2], 2'b00};
  assign bus_req_we      = (dir_q == MEM_WRITE);
  assign bus_req_wdata   = lane_wdata;
  assign bus_req_wstrb   = bus_req_we ? lane_wstrb : 4'b0000;
  // Captured request is stable in DONE; lane_mis is constant 0 without the trap build.
  assign mem_misaligned  = (state_q == DONE) && lane_mis;

endmodule

// File: tb/tb_core_stage_mem.sv
// Directed self-checking bench for core_stage_mem.
module tb_core_stage_mem;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_stage_valid;
  logic        mem_stage_ready;
  logic [31:0] mem_addr, mem_wdata;
  mem_dir_e    mem_dir;
  mem_size_e   mem_size;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_we;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic [31:0] mem_rdata;
  logic        mem_misaligned;

  int errors = 0;
  int checks = 0;

  // Observations returned by run_op
  int          o_lat;
  logic        o_seen, o_we, o_stable, o_mis, o_after;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strb;

  always #5 clk = ~clk;

  core_stage_mem dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_stage_valid(mem_stage_valid),
    .mem_stage_ready(mem_stage_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_dir        (mem_dir),
    .mem_size       (mem_size),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_req_addr   (bus_req_addr),
    .bus_req_we     (bus_req_we),
    .bus_req_wdata  (bus_req_wdata),
    .bus_req_wstrb  (bus_req_wstrb),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rsp_rdata  (bus_rsp_rdata),
    .mem_rdata      (mem_rdata),
    .mem_misaligned (mem_misaligned)
  );

  // Drives one operation and acts as the bus: holds bus_req_ready low for req_wait request
  // cycles, then waits rsp_wait cycles before responding. EXEC inputs are scrambled right after
  // capture. lat = cycles from the valid cycle to the ready pulse (-1 on timeout).
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wd, input mem_dir_e dir,
                        input mem_size_e size, input int req_wait, input int rsp_wait,
                        input logic [31:0] rd, input logic immediate);
    int   wcnt;
    int   rcnt;
    logic acc;
    wcnt = 0; rcnt = 0; acc = 1'b0;
    o_lat = -1; o_seen = 1'b0; o_stable = 1'b1; o_mis = 1'b0; o_after = 1'b1;
    o_addr = 32'h0; o_wdata = 32'h0; o_strb = 4'h0; o_we = 1'b0;
    if (!immediate) begin
      @(posedge clk); #1;
    end
    mem_stage_valid = 1'b1;
    mem_addr = addr; mem_wdata = wd; mem_dir = dir; mem_size = size;
    for (int c = 1; c <= 200 && o_lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        mem_stage_valid = 1'b0;
        mem_addr  = ~addr;
        mem_wdata = ~wd;
        mem_dir   = (dir == MEM_READ) ? MEM_WRITE : MEM_READ;
        mem_size  = (size == MEM_W) ? MEM_B : MEM_W;
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = ~rd;
      if (mem_stage_ready) begin
        o_lat = c;
        o_mis = mem_misaligned;
      end else if (bus_req_valid) begin
        if (!o_seen) begin
          o_seen = 1'b1; o_addr = bus_req_addr; o_wdata = bus_req_wdata;
          o_strb = bus_req_wstrb; o_we = bus_req_we;
        end else if (bus_req_addr !== o_addr || bus_req_wdata !== o_wdata ||
                     bus_req_wstrb !== o_strb || bus_req_we !== o_we) begin
          o_stable = 1'b0;
        end
        if (wcnt >= req_wait) begin
          bus_req_ready = 1'b1;
          acc = 1'b1;
        end
        wcnt++;
      end else if (acc) begin
        bus_rsp_rdata = rd;
        if (rcnt >= rsp_wait) bus_rsp_valid = 1'b1;
        rcnt++;
      end else if (o_seen) begin
        o_stable = 1'b0;  // request withdrawn before acceptance
      end
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    if (o_lat >= 0) begin
      @(posedge clk); #1;
      o_after = mem_stage_ready;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mem_stage_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_dir = MEM_READ; mem_size = MEM_B;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset bus_req_valid: got %b want 0", bus_req_valid); end
    checks++; if (mem_stage_ready !== 1'b0) begin errors++; $display("FAIL reset mem_stage_ready: got %b want 0", mem_stage_ready); end
    checks++; if (bus_req_addr !== 32'h0) begin errors++; $display("FAIL reset bus_req_addr: got %h want 0", bus_req_addr); end
    checks++; if (bus_req_we !== 1'b0) begin errors++; $display("FAIL reset bus_req_we: got %b want 0", bus_req_we); end
    checks++; if (bus_req_wdata !== 32'h0) begin errors++; $display("FAIL reset bus_req_wdata: got %h want 0", bus_req_wdata); end
    checks++; if (bus_req_wstrb !== 4'h0) begin errors++; $display("FAIL reset bus_req_wstrb: got %b want 0", bus_req_wstrb); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset mem_rdata: got %h want 0", mem_rdata); end
    checks++; if (mem_misaligned !== 1'b0) begin errors++; $display("FAIL reset mem_misaligned: got %b want 0", mem_misaligned); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset state: got %0d want IDLE", dut.state_q); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_loads();
    run_op(32'h0000_2002, 32'h0, MEM_READ, MEM_B, 0, 0, 32'h12F0_3456, 1'b0);
    checks++; if (o_addr !== 32'h0000_2000) begin errors++; $display("FAIL lb addr: got %h want 00002000", o_addr); end
    checks++; if (o_strb !== 4'b0000 || o_we !== 1'b0) begin errors++; $display("FAIL lb strb/we: got %b/%b want 0000/0", o_strb, o_we); end
    checks++; if (mem_rdata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb data: got %h want fffffff0", mem_rdata); end
    run_op(32'h0000_2002, 32'h0, MEM_READ, MEM_BU, 0, 0, 32'h12F0_3456, 1'b0);
    checks++; if (mem_rdata !== 32'h0000_00F0) begin errors++; $display("FAIL lbu data: got %h want 000000f0", mem_rdata); end
    run_op(32'h0000_3002, 32'h0, MEM_READ, MEM_H, 0, 0, 32'h8001_ABCD, 1'b0);
    checks++; if (mem_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh data: got %h want ffff8001", mem_rdata); end
    checks++; if (o_strb !== 4'b0000) begin errors++; $display("FAIL lh strb: got %b want 0000", o_strb); end
    run_op(32'h0000_3000, 32'h0, MEM_READ, MEM_W, 0, 0, 32'h8001_ABCD, 1'b0);
    checks++; if (mem_rdata !== 32'h8001_ABCD) begin errors++; $display("FAIL lw data: got %h want 8001abcd", mem_rdata); end
    checks++; if (o_strb !== 4'b0000 || o_addr !== 32'h0000_3000) begin errors++; $display("FAIL lw strb/addr: got %b/%h want 0000/00003000", o_strb, o_addr); end
    run_op(32'h0000_3000, 32'h0, MEM_READ, MEM_HU, 0, 0, 32'h8001_ABCD, 1'b0);
    checks++; if (mem_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu data: got %h want 0000abcd", mem_rdata); end
  endtask

  task automatic test_stores();
    run_op(32'h0000_1003, 32'h0000_00A5, MEM_WRITE, MEM_B, 0, 0, 32'h5555_5555, 1'b0);
    checks++; if (o_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb addr: got %h want 00001000", o_addr); end
    checks++; if (o_strb !== 4'b1000) begin errors++; $display("FAIL sb strb: got %b want 1000", o_strb); end
    checks++; if (o_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb wdata: got %h want a5a5a5a5", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sb we: got %b want 1", o_we); end
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL sb latency: got %0d want 3", o_lat); end
    checks++; if (mem_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL sb keeps rdata: got %h want 0000abcd", mem_rdata); end
    run_op(32'h0000_5002, 32'h1234_BEEF, MEM_WRITE, MEM_H, 0, 0, 32'h0, 1'b0);
    checks++; if (o_strb !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh lanes: got %b/%h want 1100/beefbeef", o_strb, o_wdata); end
    run_op(32'h0000_6000, 32'hDEAD_BEEF, MEM_WRITE, MEM_W, 0, 0, 32'h0, 1'b0);
    checks++; if (o_strb !== 4'b1111 || o_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw lanes: got %b/%h want 1111/deadbeef", o_strb, o_wdata); end
  endtask

  task automatic test_backpressure();
    run_op(32'h0000_3002, 32'h0, MEM_READ, MEM_H, 4, 3, 32'h8001_ABCD, 1'b0);
    checks++; if (o_lat !== 10) begin errors++; $display("FAIL bp latency: got %0d want 10", o_lat); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL bp request stable: got %b want 1", o_stable); end
    checks++; if (o_after !== 1'b0) begin errors++; $display("FAIL bp ready pulse width: second cycle got %b want 0", o_after); end
    checks++; if (mem_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL bp data: got %h want ffff8001", mem_rdata); end
    // Stray response while idle
    bus_rsp_rdata = 32'h1111_2222;
    bus_rsp_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus_rsp_valid = 1'b0;
    checks++; if (mem_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL stray rsp data: got %h want ffff8001", mem_rdata); end
    checks++; if (mem_stage_ready !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL stray rsp state: ready %b state %0d want 0/IDLE", mem_stage_ready, dut.state_q); end
  endtask

  task automatic test_misaligned();
    run_op(32'h0000_4001, 32'h0, MEM_READ, MEM_W, 0, 0, 32'h1122_3344, 1'b0);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    checks++; if (o_seen !== 1'b0) begin errors++; $display("FAIL mis lw bus request: got %b want 0", o_seen); end
    checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL mis lw flag: got %b want 1", o_mis); end
    checks++; if (o_lat !== 1) begin errors++; $display("FAIL mis lw latency: got %0d want 1", o_lat); end
    checks++; if (mem_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL mis lw data: got %h want ffff8001", mem_rdata); end
`else
    checks++; if (o_addr !== 32'h0000_4000) begin errors++; $display("FAIL mis lw addr: got %h want 00004000", o_addr); end
    checks++; if (o_mis !== 1'b0) begin errors++; $display("FAIL mis lw flag: got %b want 0", o_mis); end
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL mis lw latency: got %0d want 3", o_lat); end
    checks++; if (mem_rdata !== 32'h1122_3344) begin errors++; $display("FAIL mis lw data: got %h want 11223344", mem_rdata); end
`endif
    run_op(32'h0000_4003, 32'h0, MEM_READ, MEM_H, 0, 0, 32'h1122_3344, 1'b0);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    checks++; if (o_mis !== 1'b1 || o_seen !== 1'b0) begin errors++; $display("FAIL mis lh: flag %b req %b want 1/0", o_mis, o_seen); end
`else
    checks++; if (mem_rdata !== 32'h0000_1122 || o_mis !== 1'b0) begin errors++; $display("FAIL mis lh: data %h flag %b want 00001122/0", mem_rdata, o_mis); end
`endif
  endtask

  task automatic test_reset_mid_op();
    run_op(32'h0000_3000, 32'h0, MEM_READ, MEM_W, 0, 0, 32'h8001_ABCD, 1'b0);
    @(posedge clk); #1;
    mem_stage_valid = 1'b1; mem_addr = 32'h0000_7000; mem_dir = MEM_READ; mem_size = MEM_W;
    @(posedge clk); #1;
    mem_stage_valid = 1'b0;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    checks++; if (dut.state_q !== RESP) begin errors++; $display("FAIL rst setup state: got %0d want RESP", dut.state_q); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst bus_req_valid: got %b want 0", bus_req_valid); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst state: got %0d want IDLE", dut.state_q); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst mem_rdata: got %h want 0", mem_rdata); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    bus_rsp_rdata = 32'hCAFE_F00D;
    bus_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_rdata !== 32'h0 || mem_stage_ready !== 1'b0) begin errors++; $display("FAIL rst late rsp: data %h ready %b want 0/0", mem_rdata, mem_stage_ready); end
    run_op(32'h0000_2002, 32'h0, MEM_READ, MEM_BU, 0, 0, 32'h12F0_3456, 1'b0);
    checks++; if (o_lat !== 3 || mem_rdata !== 32'h0000_00F0) begin errors++; $display("FAIL rst next op: lat %0d data %h want 3/000000f0", o_lat, mem_rdata); end
  endtask

  task automatic test_back_to_back();
    run_op(32'h0000_8001, 32'h0000_0077, MEM_WRITE, MEM_B, 0, 0, 32'h0, 1'b0);
    checks++; if (o_strb !== 4'b0010 || o_wdata !== 32'h7777_7777) begin errors++; $display("FAIL b2b first: strb %b wdata %h want 0010/77777777", o_strb, o_wdata); end
    // Valid raised in the IDLE cycle right after DONE
    run_op(32'h0000_8002, 32'h0, MEM_READ, MEM_B, 0, 0, 32'h0080_0000, 1'b1);
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL b2b latency: got %0d want 3", o_lat); end
    checks++; if (mem_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL b2b data: got %h want ffffff80", mem_rdata); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_backpressure();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
